// File: rtl/cfg_mux_bank_pkg.sv
// Shared types and helpers for the serially reconfigurable mux bank.
package cfg_mux_bank_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FULL  = 2'd2
    } state_t;

    function automatic int sel_w(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/cfg_mux_channel.sv
// One N_IN:1 routing mux; with CFG_MUX_BANK_REG_OUT_EN defined the output is registered.
module cfg_mux_channel
    import cfg_mux_bank_pkg::*;
#(
    parameter int N_IN  = 16,
    parameter int SEL_W = 4
) (
`ifdef CFG_MUX_BANK_REG_OUT_EN
    input  logic             clk_i,
    input  logic             rst_i,
`endif
    input  logic [N_IN-1:0]  in_i,
    input  logic [SEL_W-1:0] sel_i,
    output logic             out_o
);

`ifdef CFG_MUX_BANK_REG_OUT_EN
    logic out_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_q <= 1'b0;
        end else begin
            out_q <= in_i[sel_i];
        end
    end

    assign out_o = out_q;
`else
    assign out_o = in_i[sel_i];
`endif

endmodule

// File: rtl/cfg_mux_bank.sv
// Bank of CHANNELS muxes whose selects come from a double-buffered, serially loaded
// configuration register. Optional macro: CFG_MUX_BANK_REG_OUT_EN (registered outputs).
module cfg_mux_bank
    import cfg_mux_bank_pkg::*;
#(
    parameter  int N_IN       = 16,
    parameter  int CHANNELS   = 4,
    localparam int SEL_W      = sel_w(N_IN),
    localparam int TOTAL_BITS = CHANNELS * SEL_W
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [CHANNELS*N_IN-1:0]   in_i,
    output logic [CHANNELS-1:0]        out_o,
    input  logic                       cfg_valid_i,
    input  logic                       cfg_data_i,
    output logic                       cfg_ready_o,
    input  logic                       cfg_commit_i,
    output logic                       cfg_done_o,
    output logic                       cfg_err_o,
    output logic [TOTAL_BITS-1:0]      sel_active_o
);

    localparam int CNT_W = $clog2(TOTAL_BITS + 1);

    state_t                state_q;
    logic [TOTAL_BITS-1:0] shadow_q;
    logic [TOTAL_BITS-1:0] shadow_d;
    logic [TOTAL_BITS-1:0] active_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [CNT_W-1:0]      cnt_d;
    logic                  ready_q;
    logic                  done_q;
    logic                  err_q;
    logic                  accept;

    // The sized cast drops the outgoing MSB, which also covers the single-bit register case.
    assign shadow_d = TOTAL_BITS'({shadow_q, cfg_data_i});
    assign cnt_d    = cnt_q + CNT_W'(1);
    assign accept   = cfg_valid_i && ready_q;

    // A commit in IDLE/SHIFT is checked before any same-cycle shift, so it wins and drops the bit.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            shadow_q <= '0;
            active_q <= '0;
            cnt_q    <= '0;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE, SHIFT: begin
                    if (cfg_commit_i) begin
                        err_q   <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end else if (accept) begin
                        shadow_q <= shadow_d;
                        cnt_q    <= cnt_d;
                        if (cnt_d == CNT_W'(TOTAL_BITS)) begin
                            state_q <= FULL;
                            ready_q <= 1'b0;
                        end else begin
                            state_q <= SHIFT;
                        end
                    end
                end
                FULL: begin
                    if (cfg_commit_i) begin
                        active_q <= shadow_q;
                        done_q   <= 1'b1;
                        cnt_q    <= '0;
                        state_q  <= IDLE;
                        ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign cfg_ready_o  = ready_q;
    assign cfg_done_o   = done_q;
    assign cfg_err_o    = err_q;
    assign sel_active_o = active_q;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        cfg_mux_channel #(
            .N_IN  (N_IN),
            .SEL_W (SEL_W)
        ) u_chan (
`ifdef CFG_MUX_BANK_REG_OUT_EN
            .clk_i (clk_i),
            .rst_i (rst_i),
`endif
            .in_i  (in_i[c*N_IN +: N_IN]),
            .sel_i (active_q[c*SEL_W +: SEL_W]),
            .out_o (out_o[c])
        );
    end

endmodule

// File: tb/tb_cfg_mux_bank.sv
// Directed bench for cfg_mux_bank: a 16x4 instance plus a 2:1 single-channel instance.
module tb_cfg_mux_bank;

    logic        clk;
    logic        rst;
    logic [63:0] inBus;
    logic [3:0]  outBus;
    logic        cfgValid, cfgData, cfgCommit;
    logic        cfgReady, cfgDone, cfgErr;
    logic [15:0] selActive;

    logic [1:0]  in2;
    logic        out2;
    logic        cfgValid2, cfgData2, cfgCommit2;
    logic        cfgReady2, cfgDone2, cfgErr2;
    logic        selActive2;

    int total;
    int bad;

    typedef struct {
        logic [63:0] inVal;
        logic [3:0]  expOut;
    } vec_t;

    vec_t vecs[8];

    cfg_mux_bank #(.N_IN(16), .CHANNELS(4)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .in_i         (inBus),
        .out_o        (outBus),
        .cfg_valid_i  (cfgValid),
        .cfg_data_i   (cfgData),
        .cfg_ready_o  (cfgReady),
        .cfg_commit_i (cfgCommit),
        .cfg_done_o   (cfgDone),
        .cfg_err_o    (cfgErr),
        .sel_active_o (selActive)
    );

    cfg_mux_bank #(.N_IN(2), .CHANNELS(1)) dutSmall (
        .clk_i        (clk),
        .rst_i        (rst),
        .in_i         (in2),
        .out_o        (out2),
        .cfg_valid_i  (cfgValid2),
        .cfg_data_i   (cfgData2),
        .cfg_ready_o  (cfgReady2),
        .cfg_commit_i (cfgCommit2),
        .cfg_done_o   (cfgDone2),
        .cfg_err_o    (cfgErr2),
        .sel_active_o (selActive2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Lets the mux outputs reflect the current inputs/selects.
    task automatic settle();
`ifdef CFG_MUX_BANK_REG_OUT_EN
        tick();
`else
        #1;
`endif
    endtask

    task automatic shiftBit(input logic b);
        cfgValid = 1'b1;
        cfgData  = b;
        tick();
        cfgValid = 1'b0;
    endtask

    task automatic shiftWord(input logic [15:0] value, input int nbits);
        for (int i = nbits - 1; i >= 0; i--) shiftBit(value[i]);
    endtask

    task automatic doCommit();
        cfgCommit = 1'b1;
        tick();
        cfgCommit = 1'b0;
    endtask

    task automatic applyStimulus(input logic [63:0] v);
        inBus = v;
        settle();
    endtask

    initial begin
        logic [3:0] expRst;
`ifdef CFG_MUX_BANK_REG_OUT_EN
        expRst = 4'b0000;
`else
        expRst = 4'b0001;
`endif
        total = 0;
        bad   = 0;

        vecs[0] = '{64'h0000_0000_0000_0000, 4'b0000};
        vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 4'b1111};
        vecs[2] = '{64'h0000_0000_0000_0008, 4'b0001};
        vecs[3] = '{64'h0000_0000_0400_0000, 4'b0010};
        vecs[4] = '{64'h0000_0020_0000_0000, 4'b0100};
        vecs[5] = '{64'h8000_0000_0000_0000, 4'b1000};
        vecs[6] = '{64'h7FFF_FFDF_FBFF_FFF7, 4'b0000};
        vecs[7] = '{64'h0000_0020_0000_0008, 4'b0101};

        rst = 1'b1;
        inBus = 64'h1;
        cfgValid = 0; cfgData = 0; cfgCommit = 0;
        in2 = 2'b00;
        cfgValid2 = 0; cfgData2 = 0; cfgCommit2 = 0;

        // Reset state
        #12;
        checkOutput("rst_sel", 64'(selActive), 64'h0);
        tick();
        rst = 1'b0;
        settle();
        checkOutput("rst_out", 64'(outBus), 64'h1);
        checkOutput("rst_ready", 64'(cfgReady), 64'h1);
        checkOutput("rst_done_err", 64'({cfgDone, cfgErr}), 64'h0);

        // Full load of 0xF5A3: channels 3..0 select 15, 5, 10, 3
        shiftWord(16'hF5A3, 16);
        checkOutput("full_ready_low", 64'(cfgReady), 64'h0);
        checkOutput("full_sel_before_commit", 64'(selActive), 64'h0);
        doCommit();
        checkOutput("full_done", 64'(cfgDone), 64'h1);
        checkOutput("full_err", 64'(cfgErr), 64'h0);
        checkOutput("full_sel", 64'(selActive), 64'hF5A3);
        checkOutput("full_ready_back", 64'(cfgReady), 64'h1);
        tick();
        checkOutput("full_done_pulse_end", 64'(cfgDone), 64'h0);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].inVal);
            checkOutput($sformatf("vec%0d", i), 64'(outBus), 64'(vecs[i].expOut));
        end

`ifdef CFG_MUX_BANK_REG_OUT_EN
        // Registered output: toggle on ch0's selected input shows one edge later
        applyStimulus(64'h0);
        inBus = 64'h8;
        #1;
        checkOutput("reg_before_edge", 64'(outBus), 64'h0);
        tick();
        checkOutput("reg_after_edge", 64'(outBus), 64'h1);
`endif

        // Partial stream then commit is rejected
        shiftWord(16'h0055, 7);
        checkOutput("partial_ready", 64'(cfgReady), 64'h1);
        doCommit();
        checkOutput("partial_err", 64'(cfgErr), 64'h1);
        checkOutput("partial_done", 64'(cfgDone), 64'h0);
        checkOutput("partial_sel_kept", 64'(selActive), 64'hF5A3);
        shiftWord(16'h1234, 16);
        doCommit();
        checkOutput("reload_done", 64'(cfgDone), 64'h1);
        checkOutput("reload_sel", 64'(selActive), 64'h1234);
        applyStimulus(64'h0002_0004_0008_0010);
        checkOutput("reload_out_hi", 64'(outBus), 64'hF);
        applyStimulus(~64'h0002_0004_0008_0010);
        checkOutput("reload_out_lo", 64'(outBus), 64'h0);

        // Valid and commit together mid-stream: rejected, bit dropped, count restarts
        shiftWord(16'h0007, 3);
        cfgValid = 1'b1; cfgData = 1'b1; cfgCommit = 1'b1;
        tick();
        cfgValid = 1'b0; cfgCommit = 1'b0;
        checkOutput("same_cycle_err", 64'(cfgErr), 64'h1);
        checkOutput("same_cycle_ready", 64'(cfgReady), 64'h1);
        shiftWord(16'hABCD, 16);
        doCommit();
        checkOutput("same_cycle_sel", 64'(selActive), 64'hABCD);

        // Backpressure once full: extra ones are not accepted
        shiftWord(16'h0C3E, 16);
        cfgValid = 1'b1; cfgData = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput($sformatf("bp_ready%0d", i), 64'(cfgReady), 64'h0);
        end
        cfgValid = 1'b0;
        doCommit();
        checkOutput("bp_done", 64'(cfgDone), 64'h1);
        checkOutput("bp_sel", 64'(selActive), 64'h0C3E);

        // Mid-shift reset clears everything asynchronously
        applyStimulus(64'h1);
        shiftWord(16'h01FF, 9);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midrst_sel", 64'(selActive), 64'h0);
        checkOutput("midrst_out", 64'(outBus), 64'(expRst));
        tick();
        rst = 1'b0;
        checkOutput("midrst_ready", 64'(cfgReady), 64'h1);
        settle();
        checkOutput("midrst_out_after", 64'(outBus), 64'h1);
        shiftWord(16'h0F0F, 16);
        doCommit();
        checkOutput("midrst_reload_sel", 64'(selActive), 64'h0F0F);

        // Single-channel 2:1 instance, one-bit configuration
        checkOutput("small_rst_sel", 64'(selActive2), 64'h0);
        in2 = 2'b10;
        settle();
        checkOutput("small_out_sel0", 64'(out2), 64'h0);
        cfgValid2 = 1'b1; cfgData2 = 1'b1;
        tick();
        cfgValid2 = 1'b0;
        checkOutput("small_ready_full", 64'(cfgReady2), 64'h0);
        cfgCommit2 = 1'b1;
        tick();
        cfgCommit2 = 1'b0;
        checkOutput("small_done", 64'(cfgDone2), 64'h1);
        checkOutput("small_sel", 64'(selActive2), 64'h1);
        settle();
        checkOutput("small_out_sel1", 64'(out2), 64'h1);
        in2 = 2'b01;
        settle();
        checkOutput("small_out_toggle", 64'(out2), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
